// File: rtl/gpu_pkg.sv
// Shared types and defaults for the task queue and its scheduler/core neighbours.
package gpu_pkg;

    localparam int NUM_CORES = 4;
    localparam int DATA_W    = 32;

    typedef logic [DATA_W-1:0] task_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        WAIT  = 2'd2
    } tq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with guarded push/pop; head is the oldest entry, count is registered.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push && (count_r != FULL_C);
    assign do_pop_s  = pop && (count_r != '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= data_in;
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/task_queue.sv
// Buffers host task descriptors and offers them one at a time to the scheduler,
// latching each accepted descriptor into the chosen core's task register.
module task_queue #(
    parameter int DATA_W    = gpu_pkg::DATA_W,
    parameter int DEPTH     = 8,
    parameter int NUM_CORES = gpu_pkg::NUM_CORES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          host_valid,
    input  logic [DATA_W-1:0]             host_data,
    output logic                          host_ready,
    output logic                          new_task,
    input  logic                          dispatch_task,
    input  logic [NUM_CORES-1:0]          execute_core,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*DATA_W-1:0]   core_task,
    output logic [$clog2(DEPTH):0]        count,
    output logic [7:0]                    retry_cnt,
    output logic                          proto_err
);

    import gpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    tq_state_t                   state_r;
    tq_state_t                   state_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        retry_inc_s;
    logic                        perr_set_s;
    logic [DATA_W-1:0]           head_s;
    logic [CW-1:0]               count_s;
    logic                        new_task_r;
    logic [NUM_CORES-1:0]        core_start_r;
    logic [NUM_CORES*DATA_W-1:0] core_task_r;
    logic [7:0]                  retry_cnt_r;
    logic                        proto_err_r;

    // Readiness depends only on the registered occupancy, never on a same-cycle pop.
    assign host_ready = (count_s != FULL_C);
    assign push_s     = host_valid && host_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .data_in (host_data),
        .pop     (pop_s),
        .head    (head_s),
        .count   (count_s)
    );

    // Next-state and per-cycle action decode.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        retry_inc_s = 1'b0;
        perr_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                perr_set_s = dispatch_task;
                if ((count_s != '0) || push_s) state_s = OFFER;
                else                           state_s = IDLE;
            end
            OFFER: begin
                perr_set_s = dispatch_task;
                state_s    = WAIT;
            end
            WAIT: begin
                if (dispatch_task && $onehot(execute_core)) begin
                    pop_s = 1'b1;
                    if ((count_s > ONE_C) || push_s) state_s = OFFER;
                    else                             state_s = IDLE;
                end else if (dispatch_task) begin
                    perr_set_s = 1'b1;
                    state_s    = OFFER;
                end else begin
                    retry_inc_s = 1'b1;
                    state_s     = OFFER;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Registered outputs: offer pulse, core hand-off, and sticky status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_task_r   <= 1'b0;
            core_start_r <= '0;
            core_task_r  <= '0;
            retry_cnt_r  <= 8'd0;
            proto_err_r  <= 1'b0;
        end else begin
            new_task_r   <= (state_s == OFFER);
            core_start_r <= pop_s ? execute_core : '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pop_s && execute_core[i]) core_task_r[i*DATA_W +: DATA_W] <= head_s;
            end
            if (retry_inc_s && (retry_cnt_r != 8'hFF)) retry_cnt_r <= retry_cnt_r + 8'd1;
            if (perr_set_s) proto_err_r <= 1'b1;
        end
    end

    assign new_task   = new_task_r;
    assign core_start = core_start_r;
    assign core_task  = core_task_r;
    assign count      = count_s;
    assign retry_cnt  = retry_cnt_r;
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_task_queue.sv
// Self-checking bench for task_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_task_queue;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int NUM_CORES = 4;
    localparam int TW        = NUM_CORES * DATA_W;
    localparam int P_IDLE    = 0;
    localparam int P_OFFER   = 1;
    localparam int P_WAIT    = 2;

    logic                   clk;
    logic                   reset;
    logic                   host_valid;
    logic [DATA_W-1:0]      host_data;
    logic                   host_ready;
    logic                   new_task;
    logic                   dispatch_task;
    logic [NUM_CORES-1:0]   execute_core;
    logic [NUM_CORES-1:0]   core_start;
    logic [TW-1:0]          core_task;
    logic [3:0]             count;
    logic [7:0]             retry_cnt;
    logic                   proto_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic cmp_en = 1'b0;

    // reference model state
    logic [DATA_W-1:0]    m_q[$];
    int                   m_phase = P_IDLE;
    logic [7:0]           m_retry = 8'd0;
    logic                 m_perr = 1'b0;
    logic [NUM_CORES-1:0] m_start = '0;
    logic [DATA_W-1:0]    m_core [NUM_CORES];

    task_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CORES(NUM_CORES)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .new_task      (new_task),
        .dispatch_task (dispatch_task),
        .execute_core  (execute_core),
        .core_start    (core_start),
        .core_task     (core_task),
        .count         (count),
        .retry_cnt     (retry_cnt),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO order, offer/answer handshake and sticky status from the rules.
    always @(posedge clk) begin
        int  sz;
        bit  push_ok;
        bit  onehot;
        sz      = m_q.size();
        push_ok = host_valid && (sz < DEPTH);
        onehot  = ($countones(execute_core) == 1);
        if (reset) begin
            m_q.delete();
            m_phase <= P_IDLE;
            m_retry <= 8'd0;
            m_perr  <= 1'b0;
            m_start <= '0;
            for (int i = 0; i < NUM_CORES; i++) m_core[i] <= '0;
        end else begin
            m_start <= '0;
            if (m_phase == P_IDLE) begin
                if (dispatch_task) m_perr <= 1'b1;
                if (sz > 0 || push_ok) m_phase <= P_OFFER;
            end else if (m_phase == P_OFFER) begin
                if (dispatch_task) m_perr <= 1'b1;
                m_phase <= P_WAIT;
            end else begin
                if (dispatch_task && onehot) begin
                    for (int i = 0; i < NUM_CORES; i++)
                        if (execute_core[i]) m_core[i] <= m_q[0];
                    m_start <= execute_core;
                    m_phase <= ((sz - 1 + (push_ok ? 1 : 0)) > 0) ? P_OFFER : P_IDLE;
                    void'(m_q.pop_front());
                end else if (dispatch_task) begin
                    m_perr  <= 1'b1;
                    m_phase <= P_OFFER;
                end else begin
                    if (m_retry != 8'hFF) m_retry <= m_retry + 8'd1;
                    m_phase <= P_OFFER;
                end
            end
            if (push_ok) m_q.push_back(host_data);
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [TW-1:0] exp_task;
        if (cmp_en && !reset) begin
            for (int i = 0; i < NUM_CORES; i++) exp_task[i*DATA_W +: DATA_W] = m_core[i];
            chk("host_ready", TW'(host_ready), TW'(m_q.size() < DEPTH));
            chk("new_task",   TW'(new_task),   TW'(m_phase == P_OFFER));
            chk("count",      TW'(count),      TW'(m_q.size()));
            chk("core_start", TW'(core_start), TW'(m_start));
            chk("core_task",  core_task,       exp_task);
            chk("retry_cnt",  TW'(retry_cnt),  TW'(m_retry));
            chk("proto_err",  TW'(proto_err),  TW'(m_perr));
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic push_one(input logic [DATA_W-1:0] d);
        host_valid = 1'b1;
        host_data  = d;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic answer(input logic [NUM_CORES-1:0] mask, input logic do_push,
                          input logic [DATA_W-1:0] d);
        int w = 0;
        while (!new_task && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("offer_seen", TW'(new_task), TW'(1'b1));
        @(negedge clk);
        dispatch_task = 1'b1;
        execute_core  = mask;
        host_valid    = do_push;
        host_data     = d;
        @(negedge clk);
        dispatch_task = 1'b0;
        execute_core  = '0;
        host_valid    = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        host_valid    = 1'b0;
        host_data     = '0;
        dispatch_task = 1'b0;
        execute_core  = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("rst_host_ready", TW'(host_ready), TW'(1'b1));
        chk("rst_count",      TW'(count),      TW'(0));
        chk("rst_new_task",   TW'(new_task),   TW'(1'b0));
        chk("rst_core_task",  core_task,       TW'(0));

        // 1: single task to core 2, latency 2 from offer
        push_one(32'h11);
        chk("t1_offer", TW'(new_task), TW'(1'b1));
        answer(4'b0100, 1'b0, '0);
        chk("t1_start", TW'(core_start), TW'(4'b0100));
        chk("t1_task2", TW'(core_task[2*DATA_W +: DATA_W]), TW'(32'h11));
        chk("t1_count", TW'(count), TW'(0));
        @(negedge clk);
        chk("t1_idle", TW'(new_task), TW'(1'b0));

        // 2: fill with no answers; retry counts every other cycle
        for (int i = 0; i < DEPTH; i++) push_one(32'hA0 + i);
        chk("t2_count", TW'(count), TW'(8));
        chk("t2_ready", TW'(host_ready), TW'(1'b0));
        chk("t2_retry", TW'(retry_cnt), TW'(3));
        push_one(32'h99);
        chk("t2_refused", TW'(count), TW'(8));
        chk("t2_retry4", TW'(retry_cnt), TW'(4));
        repeat (2) @(negedge clk);
        chk("t2_retry5", TW'(retry_cnt), TW'(5));

        // 5: full queue, push alongside a valid dispatch
        answer(4'b0001, 1'b1, 32'h77);
        chk("t5_count", TW'(count), TW'(7));
        chk("t5_start", TW'(core_start), TW'(4'b0001));
        chk("t5_task0", TW'(core_task[0 +: DATA_W]), TW'(32'hA0));

        // 4: non-one-hot answer, head is re-offered
        answer(4'b0110, 1'b0, '0);
        chk("t4_perr",  TW'(proto_err), TW'(1'b1));
        chk("t4_count", TW'(count), TW'(7));
        chk("t4_start", TW'(core_start), TW'(0));
        answer(4'b0100, 1'b0, '0);
        chk("t4_reoffer", TW'(core_task[2*DATA_W +: DATA_W]), TW'(32'hA1));
        answer(4'b0010, 1'b0, '0);
        answer(4'b1000, 1'b0, '0);
        chk("t6_pre_count", TW'(count), TW'(4));

        // 6: reset while in WAIT with four queued
        while (!new_task) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_count", TW'(count), TW'(0));
        chk("t6_new_task", TW'(new_task), TW'(1'b0));
        chk("t6_ready", TW'(host_ready), TW'(1'b1));
        chk("t6_perr", TW'(proto_err), TW'(1'b0));
        repeat (3) @(negedge clk);
        chk("t6_no_start", TW'(core_start), TW'(0));

        // 3: three tasks dispatched to cores 0,1,3 in push order
        push_one(32'hB0);
        push_one(32'hB1);
        push_one(32'hB2);
        answer(4'b0001, 1'b0, '0);
        chk("t3_start0", TW'(core_start), TW'(4'b0001));
        chk("t3_task0",  TW'(core_task[0 +: DATA_W]), TW'(32'hB0));
        answer(4'b0010, 1'b0, '0);
        chk("t3_start1", TW'(core_start), TW'(4'b0010));
        chk("t3_task1",  TW'(core_task[1*DATA_W +: DATA_W]), TW'(32'hB1));
        answer(4'b1000, 1'b0, '0);
        chk("t3_start3", TW'(core_start), TW'(4'b1000));
        chk("t3_task3",  TW'(core_task[3*DATA_W +: DATA_W]), TW'(32'hB2));
        chk("t3_count",  TW'(count), TW'(0));

        // stale dispatch while idle
        @(negedge clk);
        dispatch_task = 1'b1;
        execute_core  = 4'b0001;
        @(negedge clk);
        dispatch_task = 1'b0;
        execute_core  = '0;
        chk("stale_perr",  TW'(proto_err), TW'(1'b1));
        chk("stale_start", TW'(core_start), TW'(0));
        chk("stale_count", TW'(count), TW'(0));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
